// File: rtl/gerador_caminho_reverso.sv
// gerador_caminho_reverso
//   Path-reconstruction engine. Once the search core has finished, it walks the
//   predecessor ("anterior") memory from destino back to fonte, one hop per
//   memory read. Each visited node is pushed onto an internal LIFO. The path is
//   then streamed out fonte first.
//
// Optional feature (compile-time macro ANTERIOR_INVALIDO_EN):
//   The all-ones address is reserved to mean "no predecessor". Reading it, or
//   starting with an all-ones fonte/destino, ends the job in ERRO and raises
//   the sticky erro_sem_caminho output. When the macro is undefined, that port
//   does not exist and all-ones is an ordinary node address.
//
// Ports:
//   clk, rst_n          rising-edge clock; asynchronous reset, active when rst_n=1
//   start               one-cycle request, sampled only in IDLE
//   fonte_in/destino_in source/destination node, captured with start
//   mem_rd_en/addr      anterior memory read strobe and address
//   mem_rd_data         predecessor of mem_rd_addr, valid 1 cycle after the strobe
//   out_valid/ready     output handshake (see below)
//   out_addr/out_last   path node (fonte first); out_last marks destino
//   caminho_len         node count of the last walk
//   busy/done           busy in any state except IDLE; one-cycle done pulse per job
//   erro_overflow       sticky; the path did not fit in MAX_CAMINHO entries
//   erro_sem_caminho    sticky; no-predecessor marker hit (macro builds only)
//
// Handshake: a node transfers on every rising edge where out_valid && out_ready.
// out_valid never depends on out_ready. While out_ready is low, out_addr and
// out_last hold their values.
module gerador_caminho_reverso #(
    parameter  int ADDR_WIDTH  = 8,
    parameter  int MAX_CAMINHO = 64,
    localparam int LEN_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [ADDR_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic [LEN_WIDTH-1:0]  caminho_len,
    output logic                  busy,
    output logic                  done,
`ifdef ANTERIOR_INVALIDO_EN
    output logic                  erro_sem_caminho,
`endif
    output logic                  erro_overflow
);

    localparam int IDX_W = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_CAMINHO);
    localparam logic [LEN_WIDTH-1:0] UM     = LEN_WIDTH'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INICIO = 3'd1;
    localparam logic [2:0] LER    = 3'd2;
    localparam logic [2:0] ESPERA = 3'd3;
    localparam logic [2:0] EMITE  = 3'd4;
    localparam logic [2:0] FIM    = 3'd5;
    localparam logic [2:0] ERRO   = 3'd6;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] fonte_r;
    logic [ADDR_WIDTH-1:0] destino_r;
    logic [ADDR_WIDTH-1:0] cur;
    // ptr is both the LIFO fill level and the walk node count, because every
    // visited node is pushed exactly once.
    logic [LEN_WIDTH-1:0]  ptr;
    logic [ADDR_WIDTH-1:0] lifo [MAX_CAMINHO];

    logic [LEN_WIDTH-1:0]  ptr_inc;
    logic [LEN_WIDTH-1:0]  ptr_dec;
    logic                  push_walk;

    assign ptr_inc = ptr + UM;
    assign ptr_dec = ptr - UM;

`ifdef ANTERIOR_INVALIDO_EN
    localparam logic [ADDR_WIDTH-1:0] SEM_ANTERIOR = '1;
    assign push_walk = (state == ESPERA) && (mem_rd_data != SEM_ANTERIOR);
`else
    assign push_walk = (state == ESPERA);
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            fonte_r       <= '0;
            destino_r     <= '0;
            cur           <= '0;
            ptr           <= '0;
            caminho_len   <= '0;
            erro_overflow <= 1'b0;
`ifdef ANTERIOR_INVALIDO_EN
            erro_sem_caminho <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fonte_r       <= fonte_in;
                        destino_r     <= destino_in;
                        erro_overflow <= 1'b0;
                        caminho_len   <= '0;
`ifdef ANTERIOR_INVALIDO_EN
                        if (fonte_in == SEM_ANTERIOR || destino_in == SEM_ANTERIOR) begin
                            erro_sem_caminho <= 1'b1;
                            caminho_len      <= MAX_LEN;
                            state            <= ERRO;
                        end else begin
                            erro_sem_caminho <= 1'b0;
                            state            <= INICIO;
                        end
`else
                        state <= INICIO;
`endif
                    end
                end
                INICIO: begin
                    ptr <= UM;
                    cur <= destino_r;
                    if (destino_r == fonte_r) begin
                        caminho_len <= UM;
                        state       <= EMITE;
                    end else begin
                        state <= LER;
                    end
                end
                LER: state <= ESPERA;
                ESPERA: begin
`ifdef ANTERIOR_INVALIDO_EN
                    if (mem_rd_data == SEM_ANTERIOR) begin
                        erro_sem_caminho <= 1'b1;
                        caminho_len      <= MAX_LEN;
                        state            <= ERRO;
                    end else
`endif
                    begin
                        ptr <= ptr_inc;
                        cur <= mem_rd_data;
                        // Reaching fonte wins over a full LIFO: an exact fit is success.
                        if (mem_rd_data == fonte_r) begin
                            caminho_len <= ptr_inc;
                            state       <= EMITE;
                        end else if (ptr_inc == MAX_LEN) begin
                            erro_overflow <= 1'b1;
                            caminho_len   <= MAX_LEN;
                            state         <= ERRO;
                        end else begin
                            state <= LER;
                        end
                    end
                end
                EMITE: begin
                    if (out_ready) begin
                        ptr <= ptr_dec;
                        if (ptr == UM) state <= FIM;
                    end
                end
                FIM: state <= IDLE;
                ERRO: begin
                    ptr   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // LIFO storage needs no reset; its contents are only visible in EMITE.
    always_ff @(posedge clk) begin
        if (state == INICIO) begin
            lifo[0] <= destino_r;
        end else if (push_walk) begin
            lifo[ptr[IDX_W-1:0]] <= mem_rd_data;
        end
    end

    assign out_valid   = (state == EMITE);
    assign out_addr    = out_valid ? lifo[ptr_dec[IDX_W-1:0]] : '0;
    assign out_last    = out_valid && (ptr == UM);
    assign mem_rd_en   = (state == LER);
    assign mem_rd_addr = mem_rd_en ? cur : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == FIM) || (state == ERRO);

endmodule
